// File: rtl/cdc_fifo_pkg.sv
// Shared constants and types for the byte FIFO read end.
// Default widths, pointer type and output stage state encoding.
package cdc_fifo_pkg;

  localparam int DEF_DEPTH = 8;
  localparam int DEF_WIDTH = 8;
  localparam int PTR_W     = $clog2(DEF_DEPTH) + 1;

  typedef logic [DEF_WIDTH-1:0] data_t;
  typedef logic [PTR_W-1:0]     ptr_t;

  typedef enum logic {
    OUT_EMPTY,
    OUT_VALID
  } out_state_e;

endpackage

// File: rtl/cdc_fifo_mem.sv
// DEPTH x WIDTH register array.
// Synchronous write port, combinational read port.
module cdc_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents need no reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cdc_fifo_rd.sv
// Read end of the FIFO path: circular array plus registered output stage.
// Optional sticky overflow flag when CDC_FIFO_RD_OVF_EN is defined.
module cdc_fifo_rd
  import cdc_fifo_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH,
  localparam int AW   = $clog2(DEPTH),
  localparam int PW   = AW + 1,
  localparam int CW   = $clog2(DEPTH + 1) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count
`ifdef CDC_FIFO_RD_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [PW-1:0]    occ;
  logic [WIDTH-1:0] mem_rdata;
  logic             empty;
  logic             push;
  logic             pop;
  out_state_e       state;

  assign empty = (wp == rp);
  assign full  = (wp[AW-1:0] == rp[AW-1:0])
              && (wp[AW] != rp[AW]);
  assign push  = wr_en && !full;
  assign pop   = !empty
              && ((state == OUT_EMPTY) || rd_ready);
  assign occ   = wp - rp;
  assign count = CW'(occ) + CW'(rd_valid);

  cdc_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wp[AW-1:0]),
    .wdata (wr_data),
    .raddr (rp[AW-1:0]),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp       <= '0;
      rp       <= '0;
      state    <= OUT_EMPTY;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      unique case (state)
        OUT_EMPTY: begin
          if (pop) begin
            rd_data  <= mem_rdata;
            rd_valid <= 1'b1;
            state    <= OUT_VALID;
          end
        end
        OUT_VALID: begin
          if (rd_ready) begin
            if (pop) begin
              rd_data <= mem_rdata;
            end else begin
              rd_valid <= 1'b0;
              state    <= OUT_EMPTY;
            end
          end
        end
        default: begin
          rd_valid <= 1'b0;
          state    <= OUT_EMPTY;
        end
      endcase
    end
  end

`ifdef CDC_FIFO_RD_OVF_EN
  // Sticky until reset: any write attempted while full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             ovf <= 1'b0;
    else if (wr_en && full) ovf <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_cdc_fifo_rd.sv
// Self-checking bench for cdc_fifo_rd against a queue-based reference model.
// Exercises directed scenarios plus a randomized traffic phase.
module tb_cdc_fifo_rd;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
  localparam int CW    = $clog2(DEPTH + 1) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             rd_ready = 1'b0;
  logic             full;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic [CW-1:0]    count;
`ifdef CDC_FIFO_RD_OVF_EN
  logic             ovf;
`endif

  always #5 clk = ~clk;

  cdc_fifo_rd #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .count    (count)
`ifdef CDC_FIFO_RD_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  byte unsigned arr_q[$];
  bit           m_valid = 1'b0;
  byte unsigned m_data  = 8'h00;
`ifdef CDC_FIFO_RD_OVF_EN
  bit           m_ovf   = 1'b0;
`endif

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(string tag);
    check({tag, ":rd_valid"}, 32'(rd_valid), 32'(m_valid));
    if (m_valid)
      check({tag, ":rd_data"}, 32'(rd_data), 32'(m_data));
    check({tag, ":count"}, 32'(count),
          32'(arr_q.size() + int'(m_valid)));
    check({tag, ":full"}, 32'(full),
          32'(arr_q.size() == DEPTH));
`ifdef CDC_FIFO_RD_OVF_EN
    check({tag, ":ovf"}, 32'(ovf), 32'(m_ovf));
`endif
  endtask

  // Array holds DEPTH entries; output register holds one more.
  task automatic model_edge(bit w, byte unsigned d, bit r);
    bit acc;
    bit ld;
    acc = w && (arr_q.size() < DEPTH);
`ifdef CDC_FIFO_RD_OVF_EN
    if (w && !acc) m_ovf = 1'b1;
`endif
    ld = (!m_valid || r) && (arr_q.size() > 0);
    if (m_valid && r && !ld) m_valid = 1'b0;
    if (ld) begin
      m_data  = arr_q.pop_front();
      m_valid = 1'b1;
    end
    if (acc) arr_q.push_back(d);
  endtask

  task automatic step(bit w, byte unsigned d, bit r,
                      string tag);
    @(negedge clk);
    wr_en    = w;
    wr_data  = d;
    rd_ready = r;
    @(posedge clk);
    model_edge(w, d, r);
    #1;
    check_all(tag);
  endtask

  task automatic model_reset();
    arr_q.delete();
    m_valid = 1'b0;
    m_data  = 8'h00;
`ifdef CDC_FIFO_RD_OVF_EN
    m_ovf   = 1'b0;
`endif
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, ":rd_valid"}, 32'(rd_valid), 32'd0);
    check({tag, ":rd_data"}, 32'(rd_data), 32'd0);
    check({tag, ":count"}, 32'(count), 32'd0);
    check({tag, ":full"}, 32'(full), 32'd0);
`ifdef CDC_FIFO_RD_OVF_EN
    check({tag, ":ovf"}, 32'(ovf), 32'd0);
`endif
  endtask

  byte unsigned got_q[$];

  initial begin
    #2;
    check_reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Single write: visible after the second edge.
    step(1'b1, 8'hA5, 1'b0, "single_w");
    check("single_lat0", 32'(rd_valid), 32'd0);
    step(1'b0, 8'h00, 1'b0, "single_v");
    check("single_data", 32'(rd_data), 32'hA5);
    check("single_cnt", 32'(count), 32'd1);
    step(1'b0, 8'h00, 1'b0, "single_hold");
    step(1'b0, 8'h00, 1'b1, "single_pop");
    check("single_empty", 32'(count), 32'd0);

    // Fill to DEPTH+1, one dropped write, then drain.
    for (int i = 1; i <= 9; i++)
      step(1'b1, 8'(i), 1'b0, "fill");
    check("fill_full", 32'(full), 32'd1);
    check("fill_cnt", 32'(count), 32'd9);
    step(1'b1, 8'h0A, 1'b0, "fill_drop");
    check("fill_drop_cnt", 32'(count), 32'd9);
    got_q.delete();
    for (int i = 0; i < 12; i++) begin
      if (rd_valid) got_q.push_back(rd_data);
      step(1'b0, 8'h00, 1'b1, "drain");
    end
    check("drain_len", 32'(got_q.size()), 32'd9);
    for (int i = 0; i < got_q.size(); i++)
      check("drain_order", 32'(got_q[i]), 32'(i + 1));

    // Wrap: three rounds of 6 in, 6 out.
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int i = 0; i < 6; i++)
        step(1'b1, 8'(8'h40 + rnd * 8 + i), 1'b0, "wrap_w");
      for (int i = 0; i < 6; i++)
        step(1'b0, 8'h00, 1'b1, "wrap_r");
    end

    // Streaming: output trails input by one edge after loading.
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 8'(8'h80 + k), 1'b1, "stream");
      if (k > 0) begin
        check("stream_v", 32'(rd_valid), 32'd1);
        check("stream_d", 32'(rd_data), 32'(8'h80 + k - 1));
      end
    end
    for (int i = 0; i < 3; i++)
      step(1'b0, 8'h00, 1'b1, "stream_end");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      int wp_pct;
      wp_pct = (i < 200) ? 70 : 35;
      step(($urandom_range(99) < wp_pct),
           8'($urandom), ($urandom_range(99) < 50),
           "rand");
    end

    // Reset mid-stream with count = 5.
    model_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++)
      step(1'b1, 8'(8'h20 + i), 1'b0, "pre_rst");
    check("pre_rst_cnt", 32'(count), 32'd5);
    @(negedge clk);
    wr_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h3C, 1'b0, "post_rst_w");
    check("post_rst_lat", 32'(rd_valid), 32'd0);
    step(1'b0, 8'h00, 1'b0, "post_rst_v");
    check("post_rst_data", 32'(rd_data), 32'h3C);
    step(1'b0, 8'h00, 1'b1, "post_rst_pop");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
